mem_window_responder: RTL and testbench



---
 rtl/mem_window_responder.sv | 130 +++++++++++++
 tb/tb_mem_window_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_window_responder.sv
// Responder for a PicoRV32 native-memory data window. It decodes window hits,
// inserts programmable wait states and serves reads/byte-strobed writes from a word RAM.
module mem_window_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] LIMIT_ADDR  = 32'h0000_4000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             win_hit,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int unsigned DEPTH   = (LIMIT_ADDR - BASE_ADDR) / 4;
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rdata_q;
    logic [31:0]       ram [DEPTH];

    logic [31:0]       off;
    logic [IDX_W-1:0]  req_idx;
    logic              unused_bits;

    assign off         = mem_addr - BASE_ADDR;
    assign req_idx     = off[IDX_W+1:2];
    assign win_hit     = mem_valid && (mem_addr >= BASE_ADDR) && (mem_addr < LIMIT_ADDR);
    // Instruction fetches are served exactly like data reads; byte offset bits are ignored.
    assign unused_bits = ^{mem_instr, off[1:0], off[31:IDX_W+2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_hit) begin
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state_q == RESP);
        mem_rdata = '0;
        if (state_q == RESP && wstrb_q == 4'b0000) begin
            mem_rdata = rdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_hit) begin
                        idx_q      <= req_idx;
                        wdata_q    <= mem_wdata;
                        wstrb_q    <= mem_wstrb;
                        wait_cnt_q <= WS_LOAD;
                    end
                end
                WAIT: wait_cnt_q <= wait_cnt_q - 4'd1;
                RESP: begin
                    if (wstrb_q == 4'b0000) begin
                        rd_count <= rd_count + 1'b1;
                    end else begin
                        wr_count <= wr_count + 1'b1;
                    end
                end
                default: ;
            endcase
            // With zero wait states the RESP edge is also the capture edge, so read the live index.
            if (state_d == RESP) begin
                rdata_q <= (state_q == IDLE) ? ram[req_idx] : ram[idx_q];
            end
        end
    end

    // An asynchronous reset forces IDLE first, so a pending write never commits.
    always_ff @(posedge clk) begin
        if (state_q == RESP && wstrb_q != 4'b0000) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    ram[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_window_responder.sv
// Scoreboard bench for mem_window_responder: three instances cover 0, 1 and 5 wait states
// (the zero-wait one also uses 4-bit counters to exercise wrap).
module tb_mem_window_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_instr = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic        vld  [3];
    logic        rdy  [3];
    logic [31:0] rdat [3];
    logic        hitv [3];
    logic [31:0] rdc  [3];
    logic [31:0] wrc  [3];
    logic [3:0]  rc0, wc0;
    logic [15:0] rc1, wc1, rc2, wc2;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];
    logic [31:0] mdl [int];
    int unsigned exp_rd [3];
    int unsigned exp_wr [3];
    int unsigned ws   [3] = '{0, 1, 5};
    logic [31:0] mask [3] = '{32'h0000_000F, 32'h0000_FFFF, 32'h0000_FFFF};

    always #5 clk = ~clk;

    initial begin
        vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
    end

    assign rdc[0] = {28'h0, rc0};
    assign wrc[0] = {28'h0, wc0};
    assign rdc[1] = {16'h0, rc1};
    assign wrc[1] = {16'h0, wc1};
    assign rdc[2] = {16'h0, rc2};
    assign wrc[2] = {16'h0, wc2};

    mem_window_responder #(.WAIT_STATES(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(vld[0]), .mem_instr(m_instr),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
        .mem_ready(rdy[0]), .mem_rdata(rdat[0]), .win_hit(hitv[0]),
        .rd_count(rc0), .wr_count(wc0)
    );

    mem_window_responder #(.WAIT_STATES(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .mem_valid(vld[1]), .mem_instr(m_instr),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
        .mem_ready(rdy[1]), .mem_rdata(rdat[1]), .win_hit(hitv[1]),
        .rd_count(rc1), .wr_count(wc1)
    );

    mem_window_responder #(.WAIT_STATES(5), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .mem_valid(vld[2]), .mem_instr(m_instr),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
        .mem_ready(rdy[2]), .mem_rdata(rdat[2]), .win_hit(hitv[2]),
        .rd_count(rc2), .wr_count(wc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int key_of(input int s, input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'h0000_1000) >> 2;
        return s * 4096 + int'(w);
    endfunction

    task automatic xfer(input int s, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st);
        int          k;
        bit          seen;
        logic [31:0] e;
        int          key;
        key = key_of(s, a);
        e = mdl.exists(key) ? mdl[key] : 32'h0;
        if (st == 4'b0000) begin
            sb.push_back(e);
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) e[8*b +: 8] = d[8*b +: 8];
            end
            mdl[key] = e;
            sb.push_back(32'h0);
        end
        @(negedge clk);
        vld[s] = 1'b1; m_addr = a; m_wdata = d; m_wstrb = st;
        #1;
        check("win_hit", {31'h0, hitv[s]}, 32'h1);
        seen = 1'b0;
        for (k = 0; k < 30 && !seen; k++) begin
            @(posedge clk); #1;
            if (rdy[s]) begin
                seen = 1'b1;
                check("latency", k, ws[s]);
                vld[s] = 1'b0;
                check("rdata", rdat[s], sb.pop_front());
            end else begin
                check("rdata_wait", rdat[s], 32'h0);
            end
        end
        if (!seen) begin
            vld[s] = 1'b0;
            check("ready_timeout", 32'h0, 32'h1);
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        check("one_pulse", {31'h0, rdy[s]}, 32'h0);
        check("rdata_idle", rdat[s], 32'h0);
        if (st == 4'b0000) exp_rd[s]++; else exp_wr[s]++;
        check("rd_count", rdc[s], exp_rd[s] & mask[s]);
        check("wr_count", wrc[s], exp_wr[s] & mask[s]);
    endtask

    task automatic miss(input int s, input logic [31:0] a);
        int pulses;
        @(negedge clk);
        vld[s] = 1'b1; m_addr = a; m_wstrb = 4'b0000;
        #1;
        check("miss_hit", {31'h0, hitv[s]}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rdy[s]) pulses++;
        end
        check("miss_ready", pulses, 0);
        vld[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = 0; exp_wr[i] = 0;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", {31'h0, rdy[i]}, 32'h0);
            check("rst_rdata", rdat[i], 32'h0);
            check("rst_rd_count", rdc[i], 32'h0);
            check("rst_wr_count", wrc[i], 32'h0);
        end
        @(negedge clk); reset = 1'b0;

        // One wait state: full write, read back, partial write, window edges.
        xfer(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
        xfer(1, 32'h0000_1000, 32'h0, 4'b0000);
        check("rd_after_wr_cnt", rdc[1], 32'h1);
        xfer(1, 32'h0000_1004, 32'h1122_3344, 4'b1111);
        xfer(1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0101);
        xfer(1, 32'h0000_1004, 32'h0, 4'b0000);
        miss(1, 32'h0000_0FFC);
        miss(1, 32'h0000_4000);
        xfer(1, 32'h0000_3FFC, 32'h5A5A_0F0F, 4'b1111);
        m_instr = 1'b1;
        xfer(1, 32'h0000_3FFE, 32'h0, 4'b0000);
        m_instr = 1'b0;

        // Zero and five wait states.
        xfer(0, 32'h0000_1800, 32'h0BAD_F00D, 4'b1111);
        xfer(0, 32'h0000_1800, 32'h0, 4'b0000);
        xfer(2, 32'h0000_1100, 32'hCAFE_F00D, 4'b1111);
        xfer(2, 32'h0000_1100, 32'h0, 4'b0000);

        // Abort: mem_valid dropped in WAIT.
        @(negedge clk);
        vld[2] = 1'b1; m_addr = 32'h0000_1100; m_wdata = 32'h0; m_wstrb = 4'b1111;
        @(negedge clk); @(negedge clk);
        vld[2] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rdy[2]) pulses++;
        end
        check("abort_ready", pulses, 0);
        check("abort_wr_count", wrc[2], exp_wr[2] & mask[2]);
        xfer(2, 32'h0000_1100, 32'h0, 4'b0000);

        // Reset during WAIT of a write.
        xfer(2, 32'h0000_2000, 32'h1234_5678, 4'b1111);
        @(negedge clk);
        vld[2] = 1'b1; m_addr = 32'h0000_2000; m_wdata = 32'hFFFF_FFFF; m_wstrb = 4'b1111;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_ready", {31'h0, rdy[2]}, 32'h0);
        check("arst_rdata", rdat[2], 32'h0);
        check("arst_rd_count", rdc[2], 32'h0);
        check("arst_wr_count", wrc[2], 32'h0);
        vld[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = 0; exp_wr[i] = 0;
        end
        @(negedge clk); reset = 1'b0;
        xfer(2, 32'h0000_2000, 32'h0, 4'b0000);

        // 17 reads on a 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) begin
            xfer(0, 32'h0000_1800, 32'h0, 4'b0000);
        end
        check("wrap_rd_count", rdc[0], 32'h1);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
